// File: rtl/kernel_reg_ctrl.sv
// Kernel register file sequencer: LOAD writes NUM_WORDS words, RUN replays them num_passes times.
// Optional KREG_CTRL_ERR_EN adds err_clr/err sticky flag for ignored start requests.
module kernel_reg_ctrl #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 18,
  parameter int ADDR_W    = 5,
  parameter int PASS_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n_in,
`ifdef KREG_CTRL_ERR_EN
  input  logic              err_clr,
  output logic              err,
`endif
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ready,
  input  logic              run_start,
  input  logic [PASS_W-1:0] num_passes,
  output logic [ADDR_W-1:0] kr_write_addr,
  output logic              kr_write_en,
  output logic [WIDTH-1:0]  kr_din,
  output logic [ADDR_W-1:0] kr_read_addr,
  output logic              kr_read_en,
  output logic              k_valid,
  input  logic              k_ready,
  output logic              k_last_word,
  output logic              k_last,
  output logic              loaded,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] passes;

  logic is_idle, is_load, is_run;
  logic ld_hs, k_hs;
  logic wr_last, rd_last, pass_last;
  logic go_load, go_run;

  assign is_idle   = (state == S_IDLE);
  assign is_load   = (state == S_LOAD);
  assign is_run    = (state == S_RUN);
  assign ld_hs     = is_load && ld_valid;
  assign k_hs      = is_run && k_ready;
  assign wr_last   = (wr_cnt == LAST);
  assign rd_last   = (rd_cnt == LAST);
  assign pass_last = (pass_cnt == passes - PASS_W'(1));

  // Load has priority over run when both starts arrive together.
  assign go_load = is_idle && load_start;
  assign go_run  = is_idle && !load_start && run_start
                   && loaded && (num_passes != '0);

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (go_load) begin
          state_d = S_LOAD;
        end else if (go_run) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (ld_hs && wr_last) state_d = S_IDLE;
      end
      S_RUN: begin
        if (k_hs && rd_last && pass_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready      = 1'b0;
    kr_write_en   = 1'b0;
    kr_write_addr = '0;
    kr_din        = '0;
    kr_read_en    = 1'b0;
    kr_read_addr  = '0;
    k_valid       = 1'b0;
    k_last_word   = 1'b0;
    k_last        = 1'b0;
    busy          = !is_idle;
    unique case (1'b1)
      is_load: begin
        ld_ready    = 1'b1;
        kr_write_en = ld_valid;
        if (ld_valid) begin
          kr_write_addr = wr_cnt;
          kr_din        = ld_data;
        end
      end
      is_run: begin
        kr_read_en   = 1'b1;
        kr_read_addr = rd_cnt;
        k_valid      = 1'b1;
        k_last_word  = rd_last;
        k_last       = rd_last && pass_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      pass_cnt <= '0;
      passes   <= '0;
      loaded   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (ld_hs && wr_last) || (k_hs && rd_last && pass_last);
      if (go_load) begin
        wr_cnt <= '0;
        loaded <= 1'b0;
      end else if (ld_hs) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + ADDR_W'(1);
        if (wr_last) loaded <= 1'b1;
      end
      if (go_run) begin
        rd_cnt   <= '0;
        pass_cnt <= '0;
        passes   <= num_passes;
      end else if (k_hs) begin
        if (rd_last) begin
          rd_cnt   <= '0;
          pass_cnt <= pass_cnt + PASS_W'(1);
        end else begin
          rd_cnt <= rd_cnt + ADDR_W'(1);
        end
      end
    end
  end

`ifdef KREG_CTRL_ERR_EN
  logic err_set;

  // Any start request that does not change state is flagged.
  assign err_set = (!is_idle && (load_start || run_start))
                || (is_idle && run_start && !load_start && !go_run)
                || (is_idle && run_start && load_start);

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_reg_ctrl.sv
// Scoreboard bench for kernel_reg_ctrl with a behavioural register file model.
// Expected writes/reads are queued at stimulus time and popped by a monitor.
module tb_kernel_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        load_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        run_start;
  logic [15:0] num_passes;
  logic [4:0]  kr_write_addr;
  logic        kr_write_en;
  logic [15:0] kr_din;
  logic [4:0]  kr_read_addr;
  logic        kr_read_en;
  logic        k_valid;
  logic        k_ready;
  logic        k_last_word;
  logic        k_last;
  logic        loaded;
  logic        busy;
  logic        done;
`ifdef KREG_CTRL_ERR_EN
  logic        err_clr;
  logic        err;
`endif

  kernel_reg_ctrl dut (
    .clk           (clk),
    .rst_n_in      (rst_n_in),
`ifdef KREG_CTRL_ERR_EN
    .err_clr       (err_clr),
    .err           (err),
`endif
    .load_start    (load_start),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .run_start     (run_start),
    .num_passes    (num_passes),
    .kr_write_addr (kr_write_addr),
    .kr_write_en   (kr_write_en),
    .kr_din        (kr_din),
    .kr_read_addr  (kr_read_addr),
    .kr_read_en    (kr_read_en),
    .k_valid       (k_valid),
    .k_ready       (k_ready),
    .k_last_word   (k_last_word),
    .k_last        (k_last),
    .loaded        (loaded),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        lw;
    logic        last;
  } rd_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  wr_t mw;
  rd_t mr;

  logic [15:0] mem [0:31];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;
  logic       stall_prev = 1'b0;
  logic [4:0] stall_addr = '0;

  always @(posedge clk) begin
    if (kr_write_en) mem[kr_write_addr] <= kr_din;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (kr_write_en || kr_read_en)
      chk("wr_rd_excl", 32'(kr_write_en && kr_read_en), 0);
    if (!kr_write_en) chk("wr_addr_idle", 32'(kr_write_addr), 0);
    if (!kr_read_en) chk("rd_addr_idle", 32'(kr_read_addr), 0);
    if (kr_write_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexp_write", 1, 0);
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_addr", 32'(kr_write_addr), 32'(mw.addr));
        chk("wr_data", 32'(kr_din), 32'(mw.data));
      end
    end
    if (k_valid && k_ready) begin
      if (exp_rd.size() == 0) begin
        chk("unexp_read", 1, 0);
      end else begin
        mr = exp_rd.pop_front();
        chk("rd_addr", 32'(kr_read_addr), 32'(mr.addr));
        chk("rd_data", 32'(mem[kr_read_addr]), 32'(mr.data));
        chk("k_last_word", 32'(k_last_word), 32'(mr.lw));
        chk("k_last", 32'(k_last), 32'(mr.last));
      end
    end
    if (k_valid && stall_prev) chk("stall_hold", 32'(kr_read_addr), 32'(stall_addr));
    stall_prev = k_valid && !k_ready;
    stall_addr = kr_read_addr;
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_run(input int passes);
    num_passes = 16'(passes);
    run_start  = 1'b1;
    tick();
    run_start  = 1'b0;
  endtask

  task automatic load_words(input logic [15:0] base, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 2) begin
        ld_valid = 1'b0;
        ld_data  = 16'hdead;
        tick();
      end
      w.addr = 5'(i);
      w.data = base + 16'(i);
      exp_wr.push_back(w);
      ld_valid = 1'b1;
      ld_data  = w.data;
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  task automatic push_run(input logic [15:0] base, input int passes);
    rd_t r;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < 18; i++) begin
        r.addr = 5'(i);
        r.data = base + 16'(i);
        r.lw   = (i == 17);
        r.last = (i == 17) && (p == passes - 1);
        exp_rd.push_back(r);
      end
    end
  endtask

  task automatic wait_rd(input string name, input int maxc);
    int c = 0;
    while (exp_rd.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    chk(name, 32'(exp_rd.size()), 0);
  endtask

  task automatic chk_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_loaded"}, 32'(loaded), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
    chk({tag, "_k_valid"}, 32'(k_valid), 0);
    chk({tag, "_wen"}, 32'(kr_write_en), 0);
    chk({tag, "_ren"}, 32'(kr_read_en), 0);
    chk({tag, "_kr_din"}, 32'(kr_din), 0);
    chk({tag, "_k_last"}, 32'({k_last, k_last_word}), 0);
  endtask

  task automatic err_check(input string name, input logic exp_v);
`ifdef KREG_CTRL_ERR_EN
    @(negedge clk);
    chk(name, 32'(err), 32'(exp_v));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk({name, "_clr"}, 32'(err), 0);
`else
    if (exp_v) tick();
`endif
  endtask

  initial begin
    rst_n_in   = 1'b0;
    load_start = 1'b0;
    run_start  = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 16'h5a5a;
    num_passes = '0;
    k_ready    = 1'b0;
`ifdef KREG_CTRL_ERR_EN
    err_clr    = 1'b0;
`endif
    repeat (3) tick();
    chk_idle_zero("reset");
`ifdef KREG_CTRL_ERR_EN
    chk("reset_err", 32'(err), 0);
`endif
    tick();
    rst_n_in = 1'b1;
    tick();

    // T4a: run before any load is ignored
    d0 = done_cnt;
    k_ready = 1'b1;
    pulse_run(3);
    @(negedge clk);
    chk("t4a_busy", 32'(busy), 0);
    chk("t4a_kvalid", 32'(k_valid), 0);
    err_check("t4a_err", 1'b1);
    chk("t4a_done", 32'(done_cnt - d0), 0);

    // T1: load 0x0100+i with gaps
    tick();
    d0 = done_cnt;
    pulse_load();
    @(negedge clk);
    chk("t1_ld_ready", 32'(ld_ready), 1);
    tick();
    load_words(16'h0100, 18);
    repeat (3) tick();
    chk("t1_wr_drain", 32'(exp_wr.size()), 0);
    chk("t1_loaded", 32'(loaded), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done_cnt - d0), 1);

    // T2: three passes, no backpressure
    d0 = done_cnt;
    k_ready = 1'b1;
    push_run(16'h0100, 3);
    pulse_run(3);
    @(negedge clk);
    chk("t2_latency", 32'(k_valid), 1);
    wait_rd("t2_drain", 80);
    repeat (2) tick();
    chk("t2_done", 32'(done_cnt - d0), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_loaded", 32'(loaded), 1);

    // T3: one pass with toggling k_ready
    d0 = done_cnt;
    k_ready = 1'b0;
    push_run(16'h0100, 1);
    pulse_run(1);
    for (int c = 0; c < 100 && exp_rd.size() != 0; c++) begin
      k_ready = ~k_ready;
      tick();
    end
    chk("t3_drain", 32'(exp_rd.size()), 0);
    k_ready = 1'b1;
    repeat (2) tick();
    chk("t3_done", 32'(done_cnt - d0), 1);

    // T4b: num_passes == 0 is ignored
    d0 = done_cnt;
    pulse_run(0);
    @(negedge clk);
    chk("t4b_busy", 32'(busy), 0);
    err_check("t4b_err", 1'b1);
    chk("t4b_done", 32'(done_cnt - d0), 0);

    // T4c: load_start during RUN is ignored
    d0 = done_cnt;
    push_run(16'h0100, 1);
    pulse_run(1);
    repeat (4) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("t4c_busy", 32'(busy), 1);
    chk("t4c_ld_ready", 32'(ld_ready), 0);
`ifdef KREG_CTRL_ERR_EN
    chk("t4c_err", 32'(err), 1);
`endif
    wait_rd("t4c_drain", 40);
    repeat (2) tick();
    chk("t4c_loaded", 32'(loaded), 1);
    chk("t4c_done", 32'(done_cnt - d0), 1);
    err_check("t4c_err_hold", 1'b1);

    // T5: simultaneous starts, load wins
    num_passes = 16'd2;
    load_start = 1'b1;
    run_start  = 1'b1;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    @(negedge clk);
    chk("t5_ld_ready", 32'(ld_ready), 1);
    chk("t5_loaded", 32'(loaded), 0);
    chk("t5_kvalid", 32'(k_valid), 0);
`ifdef KREG_CTRL_ERR_EN
    chk("t5_err", 32'(err), 1);
`endif
    tick();
    load_words(16'h0200, 18);
    repeat (2) tick();
    chk("t5_loaded_after", 32'(loaded), 1);
    err_check("t5_err_hold", 1'b1);

    // T6a: reset at word 7 of LOAD
    pulse_load();
    load_words(16'h0300, 7);
    rst_n_in = 1'b0;
    tick();
    chk_idle_zero("t6a");
    rst_n_in = 1'b1;
    tick();
    chk("t6a_wr_drain", 32'(exp_wr.size()), 0);
    pulse_run(1);
    @(negedge clk);
    chk("t6a_run_ignored", 32'(busy), 0);
    err_check("t6a_err", 1'b1);

    // T6b: reset mid-RUN
    pulse_load();
    load_words(16'h0400, 18);
    repeat (2) tick();
    push_run(16'h0400, 2);
    pulse_run(2);
    repeat (10) tick();
    rst_n_in = 1'b0;
    tick();
    chk_idle_zero("t6b");
    exp_rd.delete();
    rst_n_in = 1'b1;
    tick();
    pulse_run(1);
    @(negedge clk);
    chk("t6b_run_ignored", 32'(busy), 0);
    chk("t6b_kvalid", 32'(k_valid), 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
